seg7_scan_driver: RTL

//  Parametrised N-digit multiplexed 7-segment scan driver with hex decode, decimal points,
//  per-digit enable, leading-zero blanking, PWM brightness and anti-ghost blanking.

---
 rtl/seg7_scan_driver.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed N-digit 7-segment scan driver. It provides hex decode, decimal points,
// per-digit enable, leading-zero blanking, PWM brightness and a blank guard at the start
// of every digit slot. Display data is double-buffered: a load fills the pending buffer,
// and the active buffer changes only at a frame boundary, so a frame is never shown half
// old and half new. The outputs are registered, one clock behind the scan state.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 8,
   parameter int REFRESH_DIV    = 100000,
   parameter int BLANK_CYCLES   = 16,
   parameter int BRIGHT_W       = 4,
   parameter bit SEL_ACTIVE_LOW = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_en,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [6:0]              seg,
   output logic                    seg_dp,
   output logic                    frame_tick
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   // Pin levels that correspond to "off" for each output group
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

   // One complete set of display settings; pending and active share this layout
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] dig;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   en;
      logic                    lz;
      logic [BRIGHT_W-1:0]     br;
   } disp_buf_t;

   disp_buf_t             in_buf, pend_q, pend_d, act_q, act_d;
   logic                  pv_q, pv_d;
   logic [PW-1:0]         pre_q, pre_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic [3:0]            cur_nib;
   logic                  cur_en, cur_dp, cur_blank;
   logic [NUM_DIGITS-1:0] blank_vec, onehot;
   logic                  above_zero, lit;
   logic [6:0]            seg_on;
   logic                  dp_on;

   // Hex-to-segment decode, active-high, bit 0 = a .. bit 6 = g
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0:    hex7 = 7'h3F;
         4'h1:    hex7 = 7'h06;
         4'h2:    hex7 = 7'h5B;
         4'h3:    hex7 = 7'h4F;
         4'h4:    hex7 = 7'h66;
         4'h5:    hex7 = 7'h6D;
         4'h6:    hex7 = 7'h7D;
         4'h7:    hex7 = 7'h07;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h6F;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h7C;
         4'hC:    hex7 = 7'h39;
         4'hD:    hex7 = 7'h5E;
         4'hE:    hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign in_buf     = {digits, dp, digit_en, lz_en, brightness};
   assign frame_tick = (pre_q == PRE_LAST) && (idx_q == IDX_LAST);
   assign pwm_d      = pwm_q + 1'b1;

   // Slot prescaler and scan index; the index advances when the prescaler wraps
   always_comb begin
      pre_d = pre_q + 1'b1;
      idx_d = idx_q;
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Double buffer: a load that coincides with the frame boundary goes straight to active
   always_comb begin
      pend_d = pend_q;
      act_d  = act_q;
      pv_d   = pv_q;
      if (load && frame_tick) begin
         act_d = in_buf;
         pv_d  = 1'b0;
      end else begin
         if (frame_tick && pv_q) begin
            act_d = pend_q;
            pv_d  = 1'b0;
         end
         if (load) begin
            pend_d = in_buf;
            pv_d   = 1'b1;
         end
      end
   end

   // Leading-zero mask: a digit blanks when it and every digit above it are zero or disabled
   always_comb begin
      above_zero = 1'b1;
      blank_vec  = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         above_zero   = above_zero & ~(act_q.en[i] & (|act_q.dig[4*i +: 4]));
         blank_vec[i] = above_zero;
      end
   end

   // Select the settings of the digit under scan
   always_comb begin
      cur_nib   = 4'h0;
      cur_en    = 1'b0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib   = act_q.dig[4*i +: 4];
            cur_en    = act_q.en[i];
            cur_dp    = act_q.dp[i];
            cur_blank = blank_vec[i];
            onehot[i] = 1'b1;
         end
      end
   end

   // Output next-state: segments are driven only while the digit is lit, so they
   // change in the same cycle as digit_sel
   always_comb begin
      lit    = (pre_q >= PRE_BLANK) && cur_en && (pwm_q < act_q.br);
      seg_on = 7'h00;
      dp_on  = 1'b0;
      if (lit) begin
         seg_on = (act_q.lz && cur_blank) ? 7'h00 : hex7(cur_nib);
         dp_on  = cur_dp;
      end
      sel_d = lit ? (onehot ^ SEL_OFF) : SEL_OFF;
      seg_d = seg_on ^ SEG_OFF;
      dp_d  = dp_on ^ DP_OFF;
   end

   // State and output registers; the async reset darkens the pins immediately
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q  <= '0;
         idx_q  <= '0;
         pwm_q  <= '0;
         pend_q <= '0;
         act_q  <= '0;
         pv_q   <= 1'b0;
         sel_q  <= SEL_OFF;
         seg_q  <= SEG_OFF;
         dp_q   <= DP_OFF;
      end else begin
         pre_q  <= pre_d;
         idx_q  <= idx_d;
         pwm_q  <= pwm_d;
         pend_q <= pend_d;
         act_q  <= act_d;
         pv_q   <= pv_d;
         sel_q  <= sel_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   assign digit_sel = sel_q;
   assign seg       = seg_q;
   assign seg_dp    = dp_q;

endmodule
